// File: rtl/gpt_pkg.sv
// Shared timer package: enumerations and widths used by the trigger-input
// conditioners and the slave-mode logic.
//   etps_e       - ETR edge prescaler selection (/1, /2, /4, /8)
//   filt_state_e - digital filter output level
//   GPT_ETF_W    - width of the filter length fields
//   psc_last()   - terminal prescaler count (N-1) for a given division
package gpt_pkg;

    localparam int GPT_ETF_W = 4;

    typedef enum logic [1:0] {
        ETPS_DIV1,
        ETPS_DIV2,
        ETPS_DIV4,
        ETPS_DIV8
    } etps_e;

    typedef enum logic {
        ST_LOW,
        ST_HIGH
    } filt_state_e;

    function automatic logic [2:0] psc_last(input etps_e div);
        logic [2:0] last;
        case (div)
            ETPS_DIV1: last = 3'd0;
            ETPS_DIV2: last = 3'd1;
            ETPS_DIV4: last = 3'd3;
            default:   last = 3'd7;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/gpt_sync_cell.sv
// Generic multi-flop synchroniser for asynchronous timer inputs (ETR, TIx).
//   clk_i      - destination clock
//   aresetn_i  - asynchronous active-low reset, chain clears to 0
//   d_i        - asynchronous input
//   q_o        - synchronised output, STAGES clocks of latency
module gpt_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic aresetn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/etr_conditioner.sv
// External trigger (ETR) receive path: synchronise, polarity-correct,
// digitally filter, detect rising edges and prescale them.
//   clk_i      - timer kernel clock
//   aresetn_i  - asynchronous active-low reset
//   etr_i      - raw trigger pin (asynchronous)
//   ece_i      - enable; 0 holds the block idle
//   etp_i      - polarity; 1 inverts the pin
//   etf_i      - filter length; 0 bypass, k needs k+1 agreeing samples
//   etps_i     - edge prescaler selection (/1, /2, /4, /8)
//   smpl_en_i  - filter sample strobe
//   etrf_o     - filtered level
//   edge_o     - one-cycle pulse per rising edge of etrf_o
//   etrp_o     - one-cycle pulse on every Nth edge_o
module etr_conditioner
    import gpt_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = GPT_ETF_W
) (
    input  logic              clk_i,
    input  logic              aresetn_i,
    input  logic              etr_i,
    input  logic              ece_i,
    input  logic              etp_i,
    input  logic [FILT_W-1:0] etf_i,
    input  logic [1:0]        etps_i,
    input  logic              smpl_en_i,
    output logic              etrf_o,
    output logic              edge_o,
    output logic              etrp_o
);

    logic              sync_out;
    logic              s;
    filt_state_e       state_q, state_d;
    logic [FILT_W-1:0] run_cnt, run_cnt_d;
    logic [FILT_W-1:0] etf_q;
    logic [1:0]        etps_q;
    logic              etrf_q;
    logic              edge_q;
    logic [2:0]        psc_cnt, psc_cnt_d;
    logic              etps_chg;
    logic              cfg_chg;
    logic              psc_wrap;

    gpt_sync_cell #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .d_i       (etr_i),
        .q_o       (sync_out)
    );

    assign s        = sync_out ^ etp_i;
    assign etps_chg = (etps_i != etps_q);
    assign cfg_chg  = etps_chg | (etf_i != etf_q);
    assign etrf_o   = (state_q == ST_HIGH);
    assign edge_o   = edge_q;

    // Filter next state: run_cnt counts consecutive samples disagreeing with
    // the current level; the level flips on the (etf_i+1)th one.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt;
        if (!ece_i) begin
            state_d   = ST_LOW;
            run_cnt_d = '0;
        end else if (etf_i == '0) begin
            state_d   = s ? ST_HIGH : ST_LOW;
            run_cnt_d = '0;
        end else if (smpl_en_i) begin
            if (s == etrf_o) begin
                run_cnt_d = '0;
            end else if (run_cnt == etf_i) begin
                state_d   = etrf_o ? ST_LOW : ST_HIGH;
                run_cnt_d = '0;
            end else begin
                run_cnt_d = run_cnt + FILT_W'(1);
            end
        end
        // A config change restarts qualification but keeps the level.
        if (cfg_chg) begin
            run_cnt_d = '0;
        end
    end

    // Prescaler: an edge landing on an etps_i change is dropped entirely
    // (counter cleared, no pulse) so a new ratio always starts a fresh group.
    always_comb begin
        psc_wrap  = edge_q && (psc_cnt == psc_last(etps_e'(etps_i)));
        psc_cnt_d = psc_cnt;
        if (!ece_i || cfg_chg) begin
            psc_cnt_d = '0;
        end else if (edge_q) begin
            psc_cnt_d = psc_wrap ? 3'd0 : psc_cnt + 3'd1;
        end
        etrp_o = psc_wrap & ~etps_chg;
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= ST_LOW;
            run_cnt <= '0;
            etf_q   <= '0;
            etps_q  <= '0;
            etrf_q  <= 1'b0;
            edge_q  <= 1'b0;
            psc_cnt <= '0;
        end else begin
            state_q <= state_d;
            run_cnt <= run_cnt_d;
            etf_q   <= etf_i;
            etps_q  <= etps_i;
            etrf_q  <= ece_i & etrf_o;
            edge_q  <= ece_i & etrf_o & ~etrf_q;
            psc_cnt <= psc_cnt_d;
        end
    end

endmodule

// File: tb/tb_etr_conditioner.sv
module tb_etr_conditioner;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       aresetn;
    logic       etr, ece, etp, smpl;
    logic [3:0] etf;
    logic [1:0] etps;
    logic       etrf_o, edge_o, etrp_o;

    int n_checks = 0;
    int n_fail   = 0;

    etr_conditioner #(
        .SYNC_STAGES (SYNC),
        .FILT_W      (4)
    ) dut (
        .clk_i     (clk),
        .aresetn_i (aresetn),
        .etr_i     (etr),
        .ece_i     (ece),
        .etp_i     (etp),
        .etf_i     (etf),
        .etps_i    (etps),
        .smpl_en_i (smpl),
        .etrf_o    (etrf_o),
        .edge_o    (edge_o),
        .etrp_o    (etrp_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Pin history: the filter sees the pin value from SYNC clocks earlier.
    bit          m_hist[$];
    bit          m_level      = 1'b0;
    bit          m_level_prev = 1'b0;
    bit          m_edge       = 1'b0;
    int unsigned m_disagree   = 0;
    int unsigned m_grp        = 0;
    logic [3:0]  m_etf_prev   = '0;
    logic [1:0]  m_etps_prev  = '0;

    always @(posedge clk or negedge aresetn) begin : model
        bit          sv;
        bit          cfg;
        bit          old_level;
        int unsigned n;
        if (!aresetn) begin
            m_hist.delete();
            for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
            m_level      = 1'b0;
            m_level_prev = 1'b0;
            m_edge       = 1'b0;
            m_disagree   = 0;
            m_grp        = 0;
            m_etf_prev   = '0;
            m_etps_prev  = '0;
        end else begin
            sv  = m_hist[0] ^ etp;
            void'(m_hist.pop_front());
            m_hist.push_back(etr);
            n   = 32'd1 << etps;
            cfg = (etps != m_etps_prev) || (etf != m_etf_prev);
            old_level = m_level;

            // group of N edges produces one trigger
            if (!ece || cfg) m_grp = 0;
            else if (m_edge) begin
                m_grp++;
                if (m_grp == n) m_grp = 0;
            end

            if (!ece) begin
                m_level = 1'b0;
                m_disagree = 0;
            end else if (etf == 4'd0) begin
                m_level = sv;
                m_disagree = 0;
            end else if (smpl) begin
                if (sv == m_level) m_disagree = 0;
                else begin
                    m_disagree++;
                    if (m_disagree == int'(etf) + 1) begin
                        m_level = ~m_level;
                        m_disagree = 0;
                    end
                end
            end
            if (cfg) m_disagree = 0;

            m_edge       = ece && old_level && !m_level_prev;
            m_level_prev = ece && old_level;
            m_etf_prev   = etf;
            m_etps_prev  = etps;
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : compare
        logic exp_trp;
        exp_trp = m_edge && (m_grp == (32'd1 << etps) - 1) && (etps == m_etps_prev);
        chk("etrf_o", etrf_o, m_level);
        chk("edge_o", edge_o, m_edge);
        chk("etrp_o", etrp_o, exp_trp);
    end

    // Pulse monitor for hand-computed expectations.
    int mon_edges = 0;
    int mon_trp   = 0;
    int mon_pos[4];
    always @(negedge clk) begin
        if (aresetn) begin
            if (edge_o) mon_edges++;
            if (etrp_o) begin
                if (mon_trp < 4) mon_pos[mon_trp] = mon_edges;
                mon_trp++;
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        mon_edges = 0;
        mon_trp   = 0;
        for (int i = 0; i < 4; i++) mon_pos[i] = 0;
    endtask

    task automatic pin_pulse();
        etr = 1'b1; tick(2);
        etr = 1'b0; tick(2);
    endtask

    task automatic strobe();
        smpl = 1'b1; tick(1);
        smpl = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        etr = 1'b0; ece = 1'b1; etp = 1'b0; smpl = 1'b0;
        etf = 4'd0; etps = 2'd0;
        tick(3);
        chk("rst_etrf", etrf_o, 1'b0);
        chk("rst_edge", edge_o, 1'b0);
        chk("rst_etrp", etrp_o, 1'b0);
        aresetn = 1'b1;
        tick(4);

        // 1: bypass latency and single pulses
        clr_mon();
        etr = 1'b1;
        tick(2); chk("t1_etrf_2clk", etrf_o, 1'b0);
        tick(1); chk("t1_etrf_3clk", etrf_o, 1'b1);
        chk("t1_edge_early", edge_o, 1'b0);
        tick(1); chk("t1_edge", edge_o, 1'b1); chk("t1_etrp", etrp_o, 1'b1);
        tick(1); chk("t1_edge_off", edge_o, 1'b0);
        tick(3); chk_int("t1_edges", mon_edges, 1); chk_int("t1_trps", mon_trp, 1);
        etr = 1'b0; tick(5);

        // 2: filter rejects a 3-strobe glitch, accepts a 4-strobe level
        etf = 4'd3; tick(2);
        etr = 1'b1; tick(3);
        for (int i = 0; i < 3; i++) begin strobe(); tick(3); end
        etr = 1'b0; tick(3);
        strobe(); tick(3);
        chk("t2_glitch", etrf_o, 1'b0);
        etr = 1'b1; tick(3);
        for (int i = 0; i < 4; i++) begin
            strobe();
            chk("t2_qualify", etrf_o, (i == 3) ? 1'b1 : 1'b0);
            tick(3);
        end
        etr = 1'b0; etf = 4'd0; tick(6);

        // 3: /8 prescaler over 16 edges
        etps = 2'd3; tick(3);
        clr_mon();
        for (int i = 0; i < 16; i++) pin_pulse();
        tick(6);
        chk_int("t3_edges", mon_edges, 16);
        chk_int("t3_trps", mon_trp, 2);
        chk_int("t3_trp0_pos", mon_pos[0], 8);
        chk_int("t3_trp1_pos", mon_pos[1], 16);

        // 4: inverted polarity triggers on the pin's falling edge
        etps = 2'd0;
        etr = 1'b1; tick(6);
        etp = 1'b1; tick(4);
        chk("t4_inv_low", etrf_o, 1'b0);
        clr_mon();
        etr = 1'b0;
        tick(3); chk("t4_etrf", etrf_o, 1'b1);
        tick(1); chk("t4_edge", edge_o, 1'b1);
        tick(3); chk_int("t4_edges", mon_edges, 1);
        etp = 1'b0; tick(5);

        // 5: etps change clears the group count
        etps = 2'd2; tick(3);
        clr_mon();
        for (int i = 0; i < 3; i++) pin_pulse();
        tick(4);
        chk_int("t5_edges3", mon_edges, 3);
        chk_int("t5_no_trp", mon_trp, 0);
        etps = 2'd1; tick(4);
        pin_pulse(); tick(4);
        chk_int("t5_after1", mon_trp, 0);
        pin_pulse(); tick(4);
        chk_int("t5_after2", mon_trp, 1);
        chk_int("t5_pos", mon_pos[0], 5);

        // 6: ece drop mid-qualification, then async reset while high
        etps = 2'd0; etf = 4'd3; tick(2);
        etr = 1'b1; tick(3);
        strobe(); tick(3);
        strobe(); tick(3);
        ece = 1'b0; tick(1);
        chk("t6_etrf", etrf_o, 1'b0);
        chk("t6_edge", edge_o, 1'b0);
        chk("t6_etrp", etrp_o, 1'b0);
        chk_int("t6_run_cnt", int'(dut.run_cnt), 0);
        ece = 1'b1; tick(1);
        clr_mon();
        for (int i = 0; i < 4; i++) begin
            strobe();
            chk("t6_requal", etrf_o, (i == 3) ? 1'b1 : 1'b0);
            if (i != 3) tick(3);
        end
        tick(1); chk("t6_edge_again", edge_o, 1'b1);
        tick(3); chk_int("t6_edges", mon_edges, 1);

        etf = 4'd0; tick(3);
        chk("t6_high", etrf_o, 1'b1);
        aresetn = 1'b0; etr = 1'b0;
        #1;
        chk("t6_rst_etrf", etrf_o, 1'b0);
        chk("t6_rst_edge", edge_o, 1'b0);
        tick(2);
        aresetn = 1'b1;
        clr_mon();
        tick(8);
        chk_int("t6_post_edges", mon_edges, 0);
        chk_int("t6_post_trps", mon_trp, 0);
        chk("t6_post_etrf", etrf_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
